// File: rtl/muldiv_issue_scheduler.sv
// Issue scheduler for the MulDiv reservation station: picks the oldest ready MUL for
// slot 0 and the oldest ready DIV for slot 1, gated by multiplier/divider capacity.
module muldiv_issue_scheduler #(
  parameter int N_RS          = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DIV_OCC       = 11,
  parameter int DIV_PIPELINED = 0,
  parameter int MAX_MUL_INFL  = 3,
  parameter int MAX_DIV_INFL  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [ROB_IDX_WIDTH-1:0]          rob_head,
  input  logic [N_RS-1:0]                   rs_valid,
  input  logic [N_RS-1:0]                   rs_ready,
  input  logic [N_RS-1:0]                   rs_is_div,
  input  logic [N_RS*ROB_IDX_WIDTH-1:0]     rs_rob_idx,
  input  logic                              mul_done,
  input  logic                              div_done,
  output logic [N_RS-1:0]                   mul_grant,
  output logic [N_RS-1:0]                   div_grant,
  output logic                              ex_valid0,
  output logic                              ex_valid1,
  output logic                              div_busy,
  output logic [$clog2(MAX_MUL_INFL+1)-1:0] mul_inflight
);
  localparam int W  = ROB_IDX_WIDTH;
  localparam int MW = $clog2(MAX_MUL_INFL+1);
  localparam int DW = $clog2(MAX_DIV_INFL+1);
  localparam int CW = (DIV_OCC > 1) ? $clog2(DIV_OCC) : 1;
  localparam logic [MW-1:0] MUL_MAX  = MW'(MAX_MUL_INFL);
  localparam logic [DW-1:0] DIV_MAX  = DW'(MAX_DIV_INFL);
  localparam logic [CW-1:0] OCC_LOAD = CW'(DIV_OCC - 1);

  // div_busy is the externally visible image of this FSM's state.
  typedef enum logic {S_IDLE, S_BUSY} div_state_t;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [MW-1:0]    mul_cnt, mul_cnt_next;
  logic [DW-1:0]    div_cnt, div_cnt_next;
  logic [W-1:0]     age [N_RS];
  logic [W-1:0]     mul_best, div_best;
  logic             mul_found, div_found;
  logic [N_RS-1:0]  mul_pick, div_pick;
  logic             mul_ok, div_ok;
  logic             kill;

  assign kill = rst | flush;

  // Oldest-first pick; strict '<' lets the lower index win an (illegal) age tie.
  always_comb begin
    mul_found = 1'b0;
    div_found = 1'b0;
    mul_best  = '0;
    div_best  = '0;
    mul_pick  = '0;
    div_pick  = '0;
    for (int i = 0; i < N_RS; i++) begin
      age[i] = rs_rob_idx[i*W +: W] - rob_head;
      if (rs_valid[i] && rs_ready[i] && !rs_is_div[i] && (!mul_found || age[i] < mul_best)) begin
        mul_found   = 1'b1;
        mul_best    = age[i];
        mul_pick    = '0;
        mul_pick[i] = 1'b1;
      end
      if (rs_valid[i] && rs_ready[i] && rs_is_div[i] && (!div_found || age[i] < div_best)) begin
        div_found   = 1'b1;
        div_best    = age[i];
        div_pick    = '0;
        div_pick[i] = 1'b1;
      end
    end
  end

  // A full unit may still accept an op when a result leaves in the same cycle.
  assign mul_ok = (mul_cnt < MUL_MAX) || (mul_cnt == MUL_MAX && mul_done);
  assign div_ok = (DIV_PIPELINED != 0)
                ? ((div_cnt < DIV_MAX) || (div_cnt == DIV_MAX && div_done))
                : (state == S_IDLE);

  assign mul_grant    = (!kill && mul_ok) ? mul_pick : '0;
  assign div_grant    = (!kill && div_ok) ? div_pick : '0;
  assign ex_valid0    = |mul_grant;
  assign ex_valid1    = |div_grant;
  assign div_busy     = (state == S_BUSY);
  assign mul_inflight = mul_cnt;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mul_cnt_next = mul_cnt + MW'(ex_valid0) - MW'(mul_done && mul_cnt != '0);
    div_cnt_next = div_cnt;
    if (DIV_PIPELINED != 0) begin
      div_cnt_next = div_cnt + DW'(ex_valid1) - DW'(div_done && div_cnt != '0);
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid1) begin
            state_next = S_BUSY;
            cnt_next   = OCC_LOAD;
          end
        end
        S_BUSY: begin
          if (cnt != '0) cnt_next = cnt - 1'b1;
          else if (div_done) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
    if (kill) begin
      state_next   = S_IDLE;
      cnt_next     = '0;
      mul_cnt_next = '0;
      div_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    state   <= state_next;
    cnt     <= cnt_next;
    mul_cnt <= mul_cnt_next;
    div_cnt <= div_cnt_next;
  end
endmodule

// File: tb/tb_muldiv_issue_scheduler.sv
// Directed bench for muldiv_issue_scheduler: each step drives one cycle of inputs,
// queues the expected outputs and compares them against the DUT mid-cycle.
module tb_muldiv_issue_scheduler;
  localparam int EW = 13;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  rob_head;
  logic [3:0]  rs_valid, rs_ready, rs_is_div;
  logic [19:0] rs_rob_idx;
  logic        mul_done, div_done;
  logic [3:0]  mul_grant, div_grant;
  logic        ex_valid0, ex_valid1, div_busy;
  logic [1:0]  mul_inflight;

  logic [EW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_is_div(rs_is_div),
    .rs_rob_idx(rs_rob_idx), .mul_done(mul_done), .div_done(div_done),
    .mul_grant(mul_grant), .div_grant(div_grant), .ex_valid0(ex_valid0),
    .ex_valid1(ex_valid1), .div_busy(div_busy), .mul_inflight(mul_inflight)
  );

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Drive one cycle of inputs after the falling edge, queue the expectation, compare.
  task automatic step(input string tag,
                      input logic [3:0] v, input logic [3:0] r, input logic [3:0] d,
                      input logic [19:0] idx, input logic [4:0] head,
                      input logic md, input logic dd, input logic fl,
                      input logic [3:0] emg, input logic [3:0] edg,
                      input logic ebusy, input logic [1:0] einfl);
    logic [EW-1:0] exp_v, obs;
    @(negedge clk);
    rs_valid = v; rs_ready = r; rs_is_div = d; rs_rob_idx = idx; rob_head = head;
    mul_done = md; div_done = dd; flush = fl;
    exp_q.push_back({emg, edg, |emg, |edg, ebusy, einfl});
    #1;
    obs = {mul_grant, div_grant, ex_valid0, ex_valid1, div_busy, mul_inflight};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed {mg,dg,ex0,ex1,busy,infl}=%b expected %b", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rob_head = '0; rs_valid = '0; rs_ready = '0;
    rs_is_div = '0; rs_rob_idx = '0; mul_done = 1'b0; div_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    step("reset",  4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0,  0, 0, 0, 4'h0, 4'h0, 0, 2'd0);
    step("oldest", 4'hF, 4'hF, 4'h0, pk(7,2,5,3), 5'd0,  0, 0, 0, 4'b0010, 4'h0, 0, 2'd0);
    step("wrap",   4'hF, 4'hF, 4'h0, pk(1,31,30,2), 5'd30, 0, 0, 0, 4'b0100, 4'h0, 0, 2'd1);
    step("drain0", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0,  1, 0, 0, 4'h0, 4'h0, 0, 2'd2);
    step("drain1", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0,  1, 0, 0, 4'h0, 4'h0, 0, 2'd1);
    step("tie",    4'b0110, 4'b0110, 4'h0, pk(5,5,5,5), 5'd0, 0, 0, 0, 4'b0010, 4'h0, 0, 2'd0);
    step("tie_dn", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0,  1, 0, 0, 4'h0, 4'h0, 0, 2'd1);

    // Multiplier capacity: three accepted, fourth blocked until a result leaves.
    for (int k = 0; k < 3; k++)
      step("mul_fill", 4'hF, 4'hF, 4'h0, pk(0,1,2,3), 5'd0, 0, 0, 0, 4'b0001, 4'h0, 0, 2'(k));
    step("mul_full", 4'hF, 4'hF, 4'h0, pk(0,1,2,3), 5'd0, 0, 0, 0, 4'h0, 4'h0, 0, 2'd3);
    step("mul_swap", 4'hF, 4'hF, 4'h0, pk(0,1,2,3), 5'd0, 1, 0, 0, 4'b0001, 4'h0, 0, 2'd3);
    step("mul_hold", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 0, 0, 0, 4'h0, 4'h0, 0, 2'd3);
    for (int k = 3; k > 0; k--)
      step("mul_drain", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 1, 0, 0, 4'h0, 4'h0, 0, 2'(k));
    step("done_at0", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 1, 0, 0, 4'h0, 4'h0, 0, 2'd0);
    step("zero",     4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 0, 0, 0, 4'h0, 4'h0, 0, 2'd0);

    // Mixed issue, then the divider occupancy window for a second divide.
    step("mixed", 4'b0011, 4'b0011, 4'b0010, pk(4,6,9,0), 5'd0, 0, 0, 0, 4'b0001, 4'b0010, 0, 2'd0);
    for (int k = 1; k <= 10; k++)
      step("div_wait", 4'b0100, 4'b0100, 4'b0100, pk(4,6,9,0), 5'd0, (k == 1), 0, 0,
           4'h0, 4'h0, 1, (k == 1) ? 2'd1 : 2'd0);
    step("div_done", 4'b0100, 4'b0100, 4'b0100, pk(4,6,9,0), 5'd0, 0, 1, 0, 4'h0, 4'h0, 1, 2'd0);
    step("div_next", 4'b0100, 4'b0100, 4'b0100, pk(4,6,9,0), 5'd0, 0, 0, 0, 4'h0, 4'b0100, 0, 2'd0);

    // Flush while the divider is busy and two multiplies are outstanding.
    step("busy_mul0", 4'b0001, 4'b0001, 4'h0, pk(4,6,9,0), 5'd0, 0, 0, 0, 4'b0001, 4'h0, 1, 2'd0);
    step("busy_mul1", 4'b0001, 4'b0001, 4'h0, pk(4,6,9,0), 5'd0, 0, 0, 0, 4'b0001, 4'h0, 1, 2'd1);
    step("flush",     4'b0101, 4'b0101, 4'b0100, pk(4,6,9,0), 5'd0, 1, 1, 1, 4'h0, 4'h0, 1, 2'd2);
    step("post_flush", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 0, 0, 0, 4'h0, 4'h0, 0, 2'd0);
    step("div_again", 4'b0100, 4'b0100, 4'b0100, pk(4,6,9,0), 5'd0, 0, 0, 0, 4'h0, 4'b0100, 0, 2'd0);
    step("busy_again", 4'h0, 4'h0, 4'h0, pk(0,0,0,0), 5'd0, 0, 0, 0, 4'h0, 4'h0, 1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
